ahb_sram_slave: RTL and testbench

- AHB-Lite memory slave sitting directly downstream of the address decoder / response multiplexer.
- It consumes one HSEL bit from the decoder. It produces the HRDATA, HREADYOUT and HRESP that feed one slot of the response mux.
- It provides MEM_WORDS x 32-bit storage with byte/halfword/word access, a programmable number of wait states and the AHB two-cycle ERROR response.

---
 rtl/ahb_sram_slave.sv | 141 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: byte/halfword/word access, fixed wait states on OKAY
// transfers, two-cycle ERROR response for misaligned, illegal-size or out-of-range accesses.
//
// state | meaning
// IDLE  | no data phase in progress, zero-wait OKAY
// WAIT  | OKAY data phase stalled, counter running down
// DATA  | final OKAY data-phase cycle, write/read happens here
// ERR1  | first ERROR cycle (HREADYOUT low)
// ERR2  | second ERROR cycle, may accept a pipelined transfer
module ahb_sram_slave #(
  parameter int MEM_WORDS   = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W:0] WORD_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t           state;
  logic [3:0]       wait_cnt;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q;
  logic [1:0]       size_q;
  logic             write_q;
  logic [31:0]      mem [MEM_WORDS];

  logic              can_accept;
  logic              accept;
  logic              bad;
  logic [ADDR_W-1:0] haddr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       rd_word;
  logic [3:0]        lane_en;
  logic [31:0]       wr_merged;
  logic              do_write;
  logic              unused_bits;

  assign unused_bits = ^{HADDR[31:ADDR_W+2], HTRANS[0]};

  assign haddr_idx  = HADDR[ADDR_W+1:2];
  assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept     = can_accept & HSEL & HREADY & HTRANS[1];
  assign bad        = (HSIZE > 3'd2)
                   || ((HSIZE == 3'd1) && HADDR[0])
                   || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                   || ({1'b0, haddr_idx} >= WORD_LIMIT);

  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      2'd0:    lane_en[lane_q] = 1'b1;
      2'd1:    lane_en = lane_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  always_comb begin
    wr_merged = mem[idx_q];
    for (int i = 0; i < 4; i++)
      if (lane_en[i]) wr_merged[8*i +: 8] = HWDATA[8*i +: 8];
  end

  assign do_write = (state == S_DATA) && write_q;

  // A read entering DATA on the same edge a write completes must see the new word.
  assign rd_idx  = (state == S_WAIT) ? idx_q : HADDR[IDX_W+1:2];
  assign rd_word = (do_write && (rd_idx == idx_q)) ? wr_merged : mem[rd_idx];

  always_ff @(posedge HCLK) begin
    if (do_write) mem[idx_q] <= wr_merged;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      idx_q     <= '0;
      lane_q    <= 2'b00;
      size_q    <= 2'b00;
      write_q   <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'd0;
    end else begin
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'd0;
      case (state)
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= S_DATA;
            if (!write_q) HRDATA <= rd_word;
          end else begin
            HREADYOUT <= 1'b0;
          end
        end
        S_ERR1: begin
          state <= S_ERR2;
          HRESP <= 1'b1;
        end
        default: begin
          if (accept) begin
            idx_q   <= HADDR[IDX_W+1:2];
            lane_q  <= HADDR[1:0];
            size_q  <= HSIZE[1:0];
            write_q <= HWRITE;
            if (bad) begin
              state     <= S_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state     <= S_WAIT;
              wait_cnt  <= 4'(WAIT_STATES);
              HREADYOUT <= 1'b0;
            end else begin
              state <= S_DATA;
              if (!HWRITE) HRDATA <= rd_word;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one slave with two wait states, one with none, checked
// cycle by cycle against a transfer-level model of memory, latency and responses.
module tb_ahb_sram_slave;
  localparam int WORDS = 64;
  localparam int LIMIT = 6000;

  logic        clk, rst, hsel, hwrite, dsel, hready_ovr, hready_val;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic        ready_a, resp_a, ready_b, resp_b, hready;
  logic [31:0] rd_a, rd_b;
  logic        obs_rdy, obs_resp;
  logic [31:0] obs_rd;

  assign hready   = hready_ovr ? hready_val : (dsel ? ready_b : ready_a);
  assign obs_rdy  = dsel ? ready_b : ready_a;
  assign obs_resp = dsel ? resp_b : resp_a;
  assign obs_rd   = dsel ? rd_b : rd_a;

  ahb_sram_slave #(.MEM_WORDS(WORDS), .ADDR_W(8), .WAIT_STATES(2)) dut_a (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel & ~dsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ready_a), .HRESP(resp_a), .HRDATA(rd_a));

  ahb_sram_slave #(.MEM_WORDS(WORDS), .ADDR_W(8), .WAIT_STATES(0)) dut_b (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel & dsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ready_b), .HRESP(resp_b), .HRDATA(rd_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] rd_log[$];
  logic [31:0] model [2][WORDS];
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit is_bad(input logic [2:0] size, input logic [31:0] addr);
    int unsigned widx;
    widx = ((addr >> 2) % 256);
    return (size > 3'd2) || (size == 3'd1 && addr % 2 != 0)
        || (size == 3'd2 && addr % 4 != 0) || (widx >= WORDS);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [2:0] size, input logic [31:0] addr);
    logic [31:0] mask;
    case (size)
      3'd0:    mask = 32'h0000_00FF << (8 * int'(addr[1:0]));
      3'd1:    mask = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old & ~mask) | (wd & mask);
  endfunction

  function automatic logic [31:0] last_rd();
    return (rd_log.size() > 0) ? rd_log[rd_log.size()-1] : 32'hxxxx_xxxx;
  endfunction

  task automatic push(input logic [1:0] t, input logic w, input logic [2:0] s,
                      input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x.sel = 1'b1; x.trans = t; x.write = w; x.size = s; x.addr = a; x.wdata = d;
    q.push_back(x);
  endtask

  // Plays the queue as a pipelined master; entered and left at posedge+1.
  task automatic run_queue();
    xfer_t       a, d;
    bit          a_v, d_v, rdy, err, last;
    int          c, iter, w, idx;
    logic [31:0] exp_rd;
    d_v = 0; c = 0; iter = 0; w = dsel ? 0 : 2;
    while ((q.size() > 0 || d_v) && iter < LIMIT) begin
      iter++;
      a_v = q.size() > 0;
      if (a_v) a = q[0];
      hsel   = a_v && a.sel;
      htrans = a_v ? a.trans : 2'b00;
      haddr  = a_v ? a.addr : 32'd0;
      hwrite = a_v && a.write;
      hsize  = a_v ? a.size : 3'd2;
      hwdata = (d_v && d.write) ? d.wdata : $urandom();
      @(negedge clk);
      err    = d_v && is_bad(d.size, d.addr);
      idx    = d_v ? int'((d.addr >> 2) % WORDS) : 0;
      last   = d_v && !err && (c == w);
      exp_rd = (last && !d.write) ? model[dsel][idx] : 32'd0;
      check("hreadyout", 32'(obs_rdy), d_v ? (err ? 32'(c >= 1) : 32'(c >= w)) : 32'd1);
      check("hresp", 32'(obs_resp), 32'(err));
      check("hrdata", obs_rd, exp_rd);
      if (last && !d.write) rd_log.push_back(obs_rd);
      rdy = hready;
      @(posedge clk); #1;
      if (rdy) begin
        if (d_v && !err && d.write) model[dsel][idx] = merge(model[dsel][idx], d.wdata, d.size, d.addr);
        d_v = 0;
        if (a_v) begin
          d = a;
          d_v = a.sel && a.trans[1];
          void'(q.pop_front());
        end
        c = 0;
      end else begin
        c++;
      end
    end
    total++;
    assert (iter < LIMIT) passed++;
    else $error("FAIL queue_timeout: iterations %0d limit %0d", iter, LIMIT);
    q.delete();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic random_traffic(input int n);
    xfer_t x;
    int    r;
    for (int i = 0; i < n; i++) begin
      r = $urandom % 8;
      x.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : ((r % 2 == 0) ? 2'b10 : 2'b11);
      x.sel   = ($urandom % 8) != 0;
      x.write = $urandom % 2;
      r = $urandom % 8;
      x.size  = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 7) ? 3'd2 : 3'($urandom_range(3, 7));
      x.addr  = $urandom % 32'h140;
      if ($urandom % 4 != 0 && x.size <= 3'd2) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
      x.wdata = $urandom();
      q.push_back(x);
    end
    run_queue();
  endtask

  logic [31:0] pre;

  initial begin
    rst = 1'b1; hsel = 1'b0; hwrite = 1'b0; dsel = 1'b0; hready_ovr = 1'b0; hready_val = 1'b1;
    htrans = 2'b00; hsize = 3'd2; haddr = 32'd0; hwdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready_a", 32'(ready_a), 32'd1);
    check("rst_resp_a", 32'(resp_a), 32'd0);
    check("rst_rdata_a", rd_a, 32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd1);
    check("rst_rdata_b", rd_b, 32'd0);
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++) begin
      dsel = s[0];
      for (int i = 0; i < WORDS; i++) push(2'b10, 1'b1, 3'd2, 32'(i * 4), $urandom());
      run_queue();
    end

    // wait states on a write then a read
    dsel = 1'b0;
    push(2'b10, 1'b1, 3'd2, 32'h04, 32'hDEADBEEF);
    push(2'b10, 1'b0, 3'd2, 32'h04, 32'd0);
    run_queue();
    check("ws_read", last_rd(), 32'hDEADBEEF);

    // byte and halfword lanes
    push(2'b10, 1'b1, 3'd2, 32'h08, 32'h0000_0000);
    push(2'b10, 1'b1, 3'd0, 32'h09, 32'h0000_AA00);
    push(2'b10, 1'b1, 3'd1, 32'h0A, 32'h1234_0000);
    push(2'b10, 1'b0, 3'd2, 32'h08, 32'd0);
    run_queue();
    check("lane_read", last_rd(), 32'h1234AA00);

    // error responses leave memory alone
    pre = model[0][0];
    push(2'b10, 1'b1, 3'd1, 32'h03, $urandom());
    push(2'b10, 1'b1, 3'd3, 32'h00, $urandom());
    push(2'b10, 1'b1, 3'd2, 32'(WORDS * 4), $urandom());
    push(2'b10, 1'b0, 3'd2, 32'h00, 32'd0);
    run_queue();
    check("err_mem_unchanged", last_rd(), pre);

    // reset in the middle of a wait-stated write aborts it
    pre = model[0][4];
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = ~pre;
    check("wait_low_before_rst", 32'(ready_a), 32'd0);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_ready", 32'(ready_a), 32'd1);
    check("rst_mid_resp", 32'(resp_a), 32'd0);
    check("rst_mid_rdata", rd_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    push(2'b10, 1'b0, 3'd2, 32'h10, 32'd0);
    run_queue();
    check("rst_abort_read", last_rd(), pre);

    // selected but bus not ready: never accepted
    pre = model[0][12];
    hready_ovr = 1'b1; hready_val = 1'b0;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h30; hwdata = ~pre;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("noacc_ready", 32'(ready_a), 32'd1);
      check("noacc_resp", 32'(resp_a), 32'd0);
      @(posedge clk); #1;
    end
    hsel = 1'b0; hready_ovr = 1'b0;
    @(negedge clk);
    check("noacc_ready_after", 32'(ready_a), 32'd1);
    @(posedge clk); #1;
    push(2'b01, 1'b1, 3'd2, 32'h30, ~pre);
    push(2'b00, 1'b1, 3'd2, 32'h30, ~pre);
    push(2'b10, 1'b0, 3'd2, 32'h30, 32'd0);
    run_queue();
    check("noacc_read", last_rd(), pre);

    // zero-wait pipelining including write then read of the same word
    dsel = 1'b1;
    rd_log.delete();
    push(2'b10, 1'b1, 3'd2, 32'h20, 32'h11111111);
    push(2'b11, 1'b1, 3'd2, 32'h24, 32'h22222222);
    push(2'b10, 1'b0, 3'd2, 32'h20, 32'd0);
    push(2'b11, 1'b0, 3'd2, 32'h24, 32'd0);
    push(2'b10, 1'b1, 3'd2, 32'h28, 32'h33333333);
    push(2'b11, 1'b0, 3'd2, 32'h28, 32'd0);
    run_queue();
    check("pipe_count", 32'(rd_log.size()), 32'd3);
    check("pipe_rd0", (rd_log.size() > 0) ? rd_log[0] : 32'hxxxx_xxxx, 32'h11111111);
    check("pipe_rd1", (rd_log.size() > 1) ? rd_log[1] : 32'hxxxx_xxxx, 32'h22222222);
    check("pipe_raw", last_rd(), 32'h33333333);

    dsel = 1'b0;
    random_traffic(150);
    dsel = 1'b1;
    random_traffic(150);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
